spi_out: RTL and testbench

Word-serial transmitter for the single-clock SPI-style link whose receiving end is the `SpiIn` word receiver. It accepts 16-bit words through a valid/ready write port and buffers them in a small FIFO. Each word is shifted out MSB-first on `MOSI`, one bit per `clock`, with `slaveChipSelectN` low for the frame. Consecutive buffered words stream with chip select held low. When the FIFO drains, chip select is released for a guaranteed gap so the receiver realigns.

---
 rtl/spi_out.sv | 147 ++++++++++++++
 tb/tb_spi_out.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_out.sv
// Word-serial SPI-style transmitter: a 16-bit word FIFO feeding an MSB-first
// shifter, with chip select held low across back-to-back words.
module spi_out #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic [15:0] wrData,
    input  logic        wrValid,
    output logic        wrReady,
    output logic        MOSI,
    output logic        slaveChipSelectN,
    output logic        busy,
    output logic        wordDone,
    output logic [4:0]  level
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    level_q, level_d;
    state_t        state_q, state_d;
    logic [15:0]   shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [3:0]    gap_cnt_q, gap_cnt_d;
    logic          cs_q, cs_d;
    logic          mosi_q, mosi_d;
    logic          done_q, done_d;
    logic          push;
    logic          pop;
    logic          not_empty;
    logic [15:0]   head;

    assign not_empty = (level_q != 5'd0);
    assign wrReady   = (level_q != 5'(FIFO_DEPTH));
    assign push      = wrValid && wrReady;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        level_d = level_q + {4'd0, push} - {4'd0, pop};
    end

    // shift_q holds the bits still to be driven, next bit in [15]
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                mosi_d = 1'b0;
                if (not_empty) begin
                    pop       = 1'b1;
                    shift_d   = {head[14:0], 1'b0};
                    mosi_d    = head[15];
                    cs_d      = 1'b0;
                    bit_cnt_d = 4'd15;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != 4'd0) begin
                    shift_d   = {shift_q[14:0], 1'b0};
                    mosi_d    = shift_q[15];
                    bit_cnt_d = bit_cnt_q - 4'd1;
                    done_d    = (bit_cnt_q == 4'd1);
                end else if (not_empty) begin
                    pop       = 1'b1;
                    shift_d   = {head[14:0], 1'b0};
                    mosi_d    = head[15];
                    bit_cnt_d = 4'd15;
                end else begin
                    cs_d      = 1'b1;
                    mosi_d    = 1'b0;
                    gap_cnt_d = 4'(GAP_CYCLES - 1);
                    state_d   = GAP;
                end
            end
            GAP: begin
                cs_d   = 1'b1;
                mosi_d = 1'b0;
                if (gap_cnt_q == 4'd0) state_d = IDLE;
                else gap_cnt_d = gap_cnt_q - 4'd1;
            end
            default: begin
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= wrData;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= 5'd0;
            state_q   <= IDLE;
            shift_q   <= 16'd0;
            bit_cnt_q <= 4'd0;
            gap_cnt_q <= 4'd0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
        end
    end

    assign MOSI             = mosi_q;
    assign slaveChipSelectN = cs_q;
    assign wordDone         = done_q;
    assign level            = level_q;
    assign busy             = (state_q != IDLE) || not_empty;

endmodule

// File: tb/tb_spi_out.sv
// Bench for spi_out: table of single-word frames plus burst, full-FIFO,
// gap, mid-frame reset and push/pop-collision sequences.
module tb_spi_out;

    localparam int DEPTH = 4;
    localparam int GAP   = 3;

    logic        clock = 1'b0;
    logic        resetN;
    logic [15:0] wrData;
    logic        wrValid;
    logic        wrReady;
    logic        MOSI;
    logic        slaveChipSelectN;
    logic        busy;
    logic        wordDone;
    logic [4:0]  level;

    spi_out #(
        .FIFO_DEPTH(DEPTH),
        .GAP_CYCLES(GAP)
    ) dut (
        .clock           (clock),
        .resetN          (resetN),
        .wrData          (wrData),
        .wrValid         (wrValid),
        .wrReady         (wrReady),
        .MOSI            (MOSI),
        .slaveChipSelectN(slaveChipSelectN),
        .busy            (busy),
        .wordDone        (wordDone),
        .level           (level)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] data;
        logic [15:0] bits;
    } vec_t;

    int          total_cnt = 0;
    int          pass_cnt  = 0;
    logic [15:0] sb[$];
    int          cyc = 0;

    int          rx_cnt = 0;
    logic [15:0] rx_sh = '0;
    int          rx_words = 0;
    int          rx_t[$];
    int          low_run = 0;
    int          high_run = 0;
    int          last_low = 0;
    int          last_high = 0;
    int          full_seen = 0;
    bit          seen_frame = 0;

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint exp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Receiver model, sampling mid-cycle on the falling edge
    initial forever begin
        logic [15:0] e;
        @(negedge clock);
        if (!resetN) begin
            rx_cnt     = 0;
            low_run    = 0;
            high_run   = 0;
            seen_frame = 0;
        end else begin
            chk(level <= DEPTH, "level_range", level, DEPTH);
            if (level == DEPTH && !wrReady) full_seen++;
            if (!slaveChipSelectN) begin
                if (high_run > 0 && seen_frame) begin
                    chk(high_run >= GAP + 1, "cs_gap_min", high_run, GAP + 1);
                    last_high = high_run;
                end
                high_run   = 0;
                seen_frame = 1;
                low_run++;
                if (wordDone) chk(rx_cnt == 15, "done_align", rx_cnt, 15);
                rx_sh = {rx_sh[14:0], MOSI};
                if (rx_cnt == 15) begin
                    rx_cnt = 0;
                    rx_words++;
                    rx_t.push_back(cyc);
                    chk(sb.size() != 0, "rx_unexpected", rx_sh, 0);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk(rx_sh == e, "rx_word", rx_sh, e);
                    end
                end else begin
                    rx_cnt++;
                end
            end else begin
                if (low_run > 0) begin
                    chk(low_run % 16 == 0, "cs_frame_len", low_run, 16);
                    last_low = low_run;
                end
                low_run = 0;
                high_run++;
                rx_cnt = 0;
                chk(!wordDone, "done_cs_high", wordDone, 0);
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after acceptance
    task automatic put(input logic [15:0] d);
        wrData  = d;
        wrValid = 1'b1;
        for (int t = 0; t < 200 && !wrReady; t++) @(negedge clock);
        chk(wrReady, "put_ready_wait", wrReady, 1);
        if (wrReady) sb.push_back(d);
        @(negedge clock);
        wrValid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 500 && busy; t++) @(negedge clock);
        chk(!busy, "idle_wait", busy, 0);
    endtask

    task automatic wait_rx(input int n);
        for (int t = 0; t < 3000 && rx_words < n; t++) @(negedge clock);
        chk(rx_words >= n, "rx_wait", rx_words, n);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [15:0] cap;
        int          dcnt, lowc, n, r0, f0;

        vecs[0] = '{16'hA53C, 16'b1010_0101_0011_1100};
        vecs[1] = '{16'h0001, 16'b0000_0000_0000_0001};
        vecs[2] = '{16'h8000, 16'b1000_0000_0000_0000};
        vecs[3] = '{16'hFFFF, 16'b1111_1111_1111_1111};
        vecs[4] = '{16'h1234, 16'b0001_0010_0011_0100};
        vecs[5] = '{16'h0000, 16'b0000_0000_0000_0000};

        resetN  = 1'b0;
        wrValid = 1'b0;
        wrData  = '0;
        repeat (2) @(negedge clock);
        chk(slaveChipSelectN == 1, "rst_cs", slaveChipSelectN, 1);
        chk(MOSI == 0, "rst_mosi", MOSI, 0);
        chk(wordDone == 0, "rst_done", wordDone, 0);
        chk(level == 0, "rst_level", level, 0);
        chk(busy == 0, "rst_busy", busy, 0);
        resetN = 1'b1;
        @(negedge clock);
        chk(wrReady == 1, "rst_ready", wrReady, 1);

        for (int v = 0; v < 6; v++) begin
            wait_idle();
            put(vecs[v].data);
            chk(slaveChipSelectN == 1, "lat_cs_before", slaveChipSelectN, 1);
            chk(level == 1, "lat_level", level, 1);
            dcnt = 0;
            lowc = 0;
            cap  = '0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clock);
                cap = {cap[14:0], MOSI};
                if (!slaveChipSelectN) lowc++;
                if (wordDone) dcnt++;
                if (i == 15) chk(wordDone == 1, "done_at_bit0", wordDone, 1);
            end
            chk(cap == vecs[v].bits, "mosi_seq", cap, vecs[v].bits);
            chk(lowc == 16, "cs_low_16", lowc, 16);
            chk(dcnt == 1, "done_count", dcnt, 1);
            @(negedge clock);
            chk(slaveChipSelectN == 1, "cs_rise", slaveChipSelectN, 1);
            chk(MOSI == 0, "mosi_gap", MOSI, 0);
            n = 0;
            for (int t = 0; t < 50 && busy; t++) begin
                n++;
                @(negedge clock);
            end
            chk(n == GAP, "busy_gap_len", n, GAP);
        end
        wait_rx(6);

        wait_idle();
        r0 = rx_t.size();
        put(16'h0001);
        put(16'h8000);
        put(16'hFFFF);
        wait_rx(rx_words + 3 - sb.size() + sb.size());
        wait_rx(9);
        wait_idle();
        chk(last_low == 48, "burst_window", last_low, 48);
        chk(rx_t.size() >= r0 + 3, "burst_rx_count", rx_t.size(), r0 + 3);
        if (rx_t.size() >= r0 + 3) begin
            chk(rx_t[r0+1] - rx_t[r0] == 16, "burst_irq_1", rx_t[r0+1] - rx_t[r0], 16);
            chk(rx_t[r0+2] - rx_t[r0+1] == 16, "burst_irq_2", rx_t[r0+2] - rx_t[r0+1], 16);
        end

        f0 = full_seen;
        for (int k = 1; k <= 6; k++) put(16'(k * 16'h1111));
        wait_rx(15);
        chk(full_seen > f0, "full_ready_low", full_seen - f0, 1);
        wait_idle();
        chk(level == 0, "full_level_zero", level, 0);
        chk(sb.size() == 0, "full_sb_drained", sb.size(), 0);

        repeat (40) @(negedge clock);
        put(16'hC0DE);
        for (int t = 0; t < 50 && slaveChipSelectN; t++) @(negedge clock);
        for (int t = 0; t < 50 && !slaveChipSelectN; t++) @(negedge clock);
        chk(slaveChipSelectN == 1, "gap_cs_high", slaveChipSelectN, 1);
        put(16'hBEEF);
        wait_rx(17);
        wait_idle();
        chk(last_high == GAP + 1, "gap_exact", last_high, GAP + 1);
        repeat (40) @(negedge clock);
        put(16'h0F0F);
        wait_rx(18);
        wait_idle();

        put(16'h1234);
        put(16'h9999);
        for (int t = 0; t < 100 && rx_cnt != 9; t++) @(negedge clock);
        #2;
        resetN = 1'b0;
        r0 = rx_words;
        #1;
        chk(slaveChipSelectN == 1, "abort_cs", slaveChipSelectN, 1);
        chk(level == 0, "abort_level", level, 0);
        chk(busy == 0, "abort_busy", busy, 0);
        chk(MOSI == 0, "abort_mosi", MOSI, 0);
        sb.delete();
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        repeat (30) @(negedge clock);
        chk(rx_words == r0, "abort_no_irq", rx_words, r0);
        put(16'h5678);
        wait_rx(r0 + 1);
        wait_idle();

        put(16'hAAAA);
        put(16'hBBBB);
        put(16'hCCCC);
        for (int t = 0; t < 50 && !wordDone; t++) @(negedge clock);
        chk(wordDone == 1, "coll_done_seen", wordDone, 1);
        chk(level == 2, "coll_level_before", level, 2);
        put(16'hDDDD);
        chk(level == 2, "coll_level_after", level, 2);
        wait_rx(r0 + 5);
        wait_idle();
        chk(sb.size() == 0, "coll_sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
